// File: rtl/cart_mapper.sv
// cart_mapper: MSX1 game-cartridge slot.
// Loads a ROM image from the download channel into cartridge BRAM and records
// its size. Outside a download it serves CPU reads in 0x4000-0xBFFF through one
// of four bank-switching schemes (plain, ASCII8, ASCII16, Konami without SCC).
//
// Ports
//   clk, reset_n             system clock, synchronous active-low reset
//   mapper_i                 0 plain, 1 ASCII8, 2 ASCII16, 3 Konami
//   dl_i, dl_addr_i,
//   dl_data_i, dl_wr_i       download channel (one strobe per byte)
//   addr_i, d_i, sltsl_n_i,
//   mreq_n_i, rd_n_i, wr_n_i CPU bus
//   mem_addr_o, mem_d_o,
//   mem_we_o, mem_q_i        cartridge BRAM (read data one clk after address)
//   d_o, oe_o                data and enable for the CPU read multiplexer
//   loaded_o                 a valid image is present
module cart_mapper #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mapper_i,
  input  logic              dl_i,
  input  logic [ADDR_W-1:0] dl_addr_i,
  input  logic [7:0]        dl_data_i,
  input  logic              dl_wr_i,
  input  logic [15:0]       addr_i,
  input  logic [7:0]        d_i,
  input  logic              sltsl_n_i,
  input  logic              mreq_n_i,
  input  logic              rd_n_i,
  input  logic              wr_n_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_d_o,
  output logic              mem_we_o,
  input  logic [7:0]        mem_q_i,
  output logic [7:0]        d_o,
  output logic              oe_o,
  output logic              loaded_o
);

  // Number of 8 KB page-index bits needed to span the cartridge memory.
  localparam int PG_W = ADDR_W - 13;

  logic              dl_p1;
  logic              wstb;
  logic              wstb_p1;
  logic              wr_pulse;
  logic              dl_rise;
  logic              dl_fall;
  logic              dl_acc;
  logic [ADDR_W:0]   dl_end;
  logic [ADDR_W:0]   top;
  logic              dl_ok;
  logic              loaded;
  logic [7:0]        page_mask;
  logic [7:0]        page_mask_nxt;
  logic [ADDR_W-1:0] byte_mask;
  logic [7:0]        b0, b1, b2, b3;
  logic [2:0]        win;
  logic [7:0]        bank_sel;
  logic [8:0]        idx;
  logic [8:0]        idx_m;
  logic [ADDR_W-1:0] cpu_addr;
  logic              in_window;
  logic              unused_idx;

  // Power-on / download-start bank values: Konami boots with pages 0..3
  // mapped linearly, every other scheme starts with all banks at page 0.
  function automatic logic [7:0] bank_default(input logic [1:0] mapper,
                                              input logic [1:0] n);
    return (mapper == 2'd3) ? {6'd0, n} : 8'd0;
  endfunction

  // Page mask from the image size: round the page count up to a power of
  // two, minus one. An empty image gives 0.
  function automatic logic [7:0] page_mask_of(input logic [ADDR_W:0] t);
    logic [ADDR_W:0] sum;
    logic [7:0]      pm;
    sum = t + (ADDR_W+1)'(13'h1FFF);
    pm  = 8'(sum >> 13);
    if (pm != 8'd0) pm = pm - 8'd1;
    pm = pm | (pm >> 1);
    pm = pm | (pm >> 2);
    pm = pm | (pm >> 4);
    return pm;
  endfunction

  assign wstb     = ~sltsl_n_i & ~mreq_n_i & ~wr_n_i;
  // Only the first cycle of a write strobe counts, and never during a download,
  // so a download starting together with a CPU write discards the write.
  assign wr_pulse = wstb & ~wstb_p1 & ~dl_i;
  assign dl_rise  = dl_i & ~dl_p1;
  assign dl_fall  = ~dl_i & dl_p1;
  assign dl_acc   = dl_i & dl_wr_i;
  assign dl_end   = {1'b0, dl_addr_i} + {{ADDR_W{1'b0}}, 1'b1};
  assign page_mask_nxt = page_mask_of(top);

  // ---- stage p1: download bookkeeping, edge detects, bank registers ----
  always_ff @(posedge clk) begin
    // dl_p1 tracks dl_i even through reset, so a reset in the middle of a
    // download is not seen as a new download start.
    dl_p1 <= dl_i;
    if (!reset_n) begin
      wstb_p1   <= 1'b0;
      top       <= '0;
      dl_ok     <= 1'b0;
      loaded    <= 1'b0;
      page_mask <= 8'd0;
      byte_mask <= {{PG_W{1'b0}}, 13'h1FFF};
      b0        <= bank_default(mapper_i, 2'd0);
      b1        <= bank_default(mapper_i, 2'd1);
      b2        <= bank_default(mapper_i, 2'd2);
      b3        <= bank_default(mapper_i, 2'd3);
    end else begin
      wstb_p1 <= wstb;
      if (dl_rise) begin
        top    <= dl_acc ? dl_end : '0;
        dl_ok  <= 1'b1;
        loaded <= 1'b0;
        b0     <= bank_default(mapper_i, 2'd0);
        b1     <= bank_default(mapper_i, 2'd1);
        b2     <= bank_default(mapper_i, 2'd2);
        b3     <= bank_default(mapper_i, 2'd3);
      end else begin
        if (dl_acc && (dl_end > top)) top <= dl_end;
        // dl_ok is only set by an observed download start, so a download
        // cut by reset never marks the image as loaded.
        if (dl_fall) begin
          loaded    <= dl_ok && (top != '0);
          dl_ok     <= 1'b0;
          page_mask <= page_mask_nxt;
          byte_mask <= {page_mask_nxt[PG_W-1:0], 13'h1FFF};
        end
        if (wr_pulse) begin
          case (mapper_i)
            2'd1: begin
              if (addr_i[15:13] == 3'b011) begin
                case (addr_i[12:11])
                  2'd0:    b0 <= d_i;
                  2'd1:    b1 <= d_i;
                  2'd2:    b2 <= d_i;
                  default: b3 <= d_i;
                endcase
              end
            end
            2'd2: begin
              if (addr_i[15:11] == 5'b01100) b0 <= d_i;
              else if (addr_i[15:11] == 5'b01110) b1 <= d_i;
            end
            2'd3: begin
              case (addr_i[15:13])
                3'd3:    b1 <= d_i;
                3'd4:    b2 <= d_i;
                3'd5:    b3 <= d_i;
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---- combinational address mapping and read path ----
  // 8 KB window number relative to 0x4000: 0..3 inside the cartridge window.
  assign win = addr_i[15:13] - 3'd2;

  always_comb begin
    case (win[1:0])
      2'd0:    bank_sel = b0;
      2'd1:    bank_sel = b1;
      2'd2:    bank_sel = b2;
      default: bank_sel = b3;
    endcase
  end

  always_comb begin
    idx = 9'd0;
    case (mapper_i)
      2'd0: idx = {6'd0, win};
      2'd1: idx = {1'b0, bank_sel};
      2'd2: idx = {(addr_i[15] ? b1 : b0), addr_i[13]};
      default: idx = (win[1:0] == 2'd0) ? 9'd0 : {1'b0, bank_sel};
    endcase
  end

  // Bank values beyond the image wrap around through the page mask.
  assign idx_m      = idx & {1'b0, page_mask};
  assign unused_idx = ^idx_m[8:PG_W];
  assign cpu_addr   = {idx_m[PG_W-1:0], addr_i[12:0]} & byte_mask;

  assign mem_addr_o = dl_i ? dl_addr_i : cpu_addr;
  assign mem_d_o    = dl_data_i;
  assign mem_we_o   = dl_acc;

  assign in_window = (addr_i[15:14] == 2'b01) || (addr_i[15:14] == 2'b10);
  assign oe_o      = loaded & ~dl_i & ~sltsl_n_i & ~mreq_n_i & ~rd_n_i & in_window;
  assign d_o       = oe_o ? mem_q_i : 8'hFF;
  assign loaded_o  = loaded;

endmodule
